// File: rtl/fir_y_stream_sink.sv
// Consuming end of the FIR y stream: accepts a programmed number of beats into a
// small FIFO drained by a registered read port, and tracks beat count and checksum.
module fir_y_stream_sink #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic                      enable_i,
  input  logic                      start_i,
  input  logic [CNT_WIDTH-1:0]      len_i,
  input  logic [DATA_WIDTH-1:0]     y_data_i,
  input  logic [DATA_WIDTH/8-1:0]   y_strb_i,
  input  logic                      y_valid_i,
  output logic                      y_ready_o,
  input  logic                      rd_req_i,
  output logic [DATA_WIDTH-1:0]     rd_data_o,
  output logic                      rd_valid_o,
  output logic [$clog2(DEPTH):0]    fifo_cnt_o,
  output logic [CNT_WIDTH-1:0]      beat_cnt_o,
  output logic [DATA_WIDTH-1:0]     checksum_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0] OCC_ONE = (AW+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic [DATA_WIDTH-1:0] rotl1(input logic [DATA_WIDTH-1:0] v);
    return {v[DATA_WIDTH-2:0], v[DATA_WIDTH-1]};
  endfunction

  state_e                  r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0]    r_len, r_beat_cnt;
  logic [DATA_WIDTH-1:0]   r_checksum;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic [AW-1:0]           r_wr_ptr, r_rd_ptr;
  logic [AW:0]             r_count;
  logic [DATA_WIDTH-1:0]   r_rd_data;
  logic                    r_rd_valid;

  logic                    w_full, w_empty, w_at_len;
  logic                    w_push, w_pop, w_ready;
  logic                    w_len_load, w_cnt_zero;
  logic [CNT_WIDTH-1:0]    w_beat_inc;
  logic [DATA_WIDTH-1:0]   w_masked;

  assign w_full     = (r_count == FULL_CNT);
  assign w_empty    = (r_count == '0);
  assign w_at_len   = (r_beat_cnt == r_len);
  assign w_beat_inc = r_beat_cnt + CNT_ONE;
  // Ready is derived only from registered state and enable, never from valid.
  assign w_ready    = (r_state == S_RUN) & enable_i & ~w_full & ~w_at_len;
  assign w_push     = y_valid_i & w_ready;
  assign w_pop      = rd_req_i & ~w_empty;

  // Byte-mask the incoming word with its strobe.
  always_comb begin
    w_masked = '0;
    for (int b = 0; b < STRB_W; b++) begin
      if (y_strb_i[b]) begin
        w_masked[8*b +: 8] = y_data_i[8*b +: 8];
      end else begin
        w_masked[8*b +: 8] = 8'h00;
      end
    end
  end

  // Next-state logic for the transfer controller.
  always_comb begin
    w_state_nxt = r_state;
    w_len_load  = 1'b0;
    w_cnt_zero  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_cnt_zero = 1'b1;
          if (len_i != '0) begin
            w_len_load  = 1'b1;
            w_state_nxt = S_RUN;
          end else begin
            w_state_nxt = S_DONE;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_push && (w_beat_inc == r_len)) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Controller state, programmed length, beat counter and checksum.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_beat_cnt <= '0;
      r_checksum <= '0;
    end else if (clear_i) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_beat_cnt <= '0;
      r_checksum <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_len_load) begin
        r_len <= len_i;
      end
      if (w_cnt_zero) begin
        r_beat_cnt <= '0;
        r_checksum <= '0;
      end else if (w_push) begin
        r_beat_cnt <= w_beat_inc;
        r_checksum <= rotl1(r_checksum) ^ w_masked;
      end
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves occupancy unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + OCC_ONE;
        2'b01:   r_count <= r_count - OCC_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_masked;
    end
  end

  // Registered read port: data appears the cycle after a successful pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else if (clear_i) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_pop;
      if (w_pop) begin
        r_rd_data <= r_mem[r_rd_ptr];
      end
    end
  end

  assign y_ready_o  = w_ready;
  assign rd_data_o  = r_rd_data;
  assign rd_valid_o = r_rd_valid;
  assign fifo_cnt_o = r_count;
  assign beat_cnt_o = r_beat_cnt;
  assign checksum_o = r_checksum;
  assign busy_o     = (r_state != S_IDLE);
  assign done_o     = (r_state == S_DONE);

endmodule

// File: tb/tb_fir_y_stream_sink.sv
// Directed bench for fir_y_stream_sink: basic transfer, backpressure, strobe,
// zero length, empty read, clear/reset mid-run and a randomised stall run.
module tb_fir_y_stream_sink;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        enable = 1'b1;
  logic        start = 1'b0;
  logic [15:0] len = 16'd0;
  logic [31:0] y_data = 32'h0;
  logic [3:0]  y_strb = 4'h0;
  logic        y_valid = 1'b0;
  logic        y_ready;
  logic        rd_req = 1'b0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [4:0]  fifo_cnt;
  logic [15:0] beat_cnt;
  logic [31:0] checksum;
  logic        busy, done;

  int n_checks = 0;
  int n_errors = 0;
  int n_sent = 0;
  int n_rx = 0;
  logic [31:0] exp_sum = 32'h0;

  fir_y_stream_sink #(.DATA_WIDTH(32), .DEPTH(16), .CNT_WIDTH(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .enable_i(enable),
    .start_i(start), .len_i(len),
    .y_data_i(y_data), .y_strb_i(y_strb), .y_valid_i(y_valid), .y_ready_o(y_ready),
    .rd_req_i(rd_req), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .fifo_cnt_o(fifo_cnt), .beat_cnt_o(beat_cnt), .checksum_o(checksum),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] v);
    return {v[30:0], v[31]};
  endfunction

  function automatic logic [31:0] golden(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_5A5A;
  endfunction

  // Called just after a falling edge; returns just after the falling edge following acceptance.
  task automatic send_beat(input logic [31:0] d, input logic [3:0] s);
    int k;
    k = 0;
    y_data = d; y_strb = s; y_valid = 1'b1;
    #1;
    while (!y_ready && k < 200) begin
      @(negedge clk); #1; k++;
    end
    if (!y_ready) check_eq("send_timeout", 32'(k), 32'd0);
    @(posedge clk);
    @(negedge clk);
    y_valid = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [31:0] exp);
    rd_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rd_req = 1'b0;
    check_eq({tag, "_valid"}, 32'(rd_valid), 32'd1);
    check_eq(tag, rd_data, exp);
  endtask

  task automatic do_start(input logic [15:0] l);
    start = 1'b1; len = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_idle_empty(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_fifo"}, 32'(fifo_cnt), 32'd0);
    check_eq({tag, "_beat"}, 32'(beat_cnt), 32'd0);
    check_eq({tag, "_sum"}, checksum, 32'd0);
    y_valid = 1'b1; #1;
    check_eq({tag, "_ready"}, 32'(y_ready), 32'd0);
    y_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 32'(y_ready), 32'd0);
    check_eq("rst_rd_data", rd_data, 32'd0);
    check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_fifo", 32'(fifo_cnt), 32'd0);
    check_eq("rst_beat", 32'(beat_cnt), 32'd0);
    check_eq("rst_sum", checksum, 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic: four beats, full strobe
    do_start(16'd4);
    check_eq("basic_busy", 32'(busy), 32'd1);
    send_beat(32'h11, 4'hF);
    send_beat(32'h22, 4'hF);
    send_beat(32'h33, 4'hF);
    send_beat(32'h44, 4'hF);
    check_eq("basic_done", 32'(done), 32'd1);
    check_eq("basic_beat", 32'(beat_cnt), 32'd4);
    check_eq("basic_fifo", 32'(fifo_cnt), 32'd4);
    check_eq("basic_sum", checksum, 32'h0000_0022);
    @(negedge clk);
    check_eq("basic_done_drop", 32'(done), 32'd0);
    check_eq("basic_idle", 32'(busy), 32'd0);
    pop_check("basic_rd0", 32'h11);
    pop_check("basic_rd1", 32'h22);
    pop_check("basic_rd2", 32'h33);
    pop_check("basic_rd3", 32'h44);

    // Backpressure: len 20 into a 16-deep FIFO
    do_start(16'd20);
    for (int i = 0; i < 16; i++) send_beat(32'h100 + 32'(i), 4'hF);
    check_eq("bp_full", 32'(fifo_cnt), 32'd16);
    y_valid = 1'b1; #1;
    check_eq("bp_ready_full", 32'(y_ready), 32'd0);
    rd_req = 1'b1; #1;
    check_eq("bp_ready_popcyc", 32'(y_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rd_req = 1'b0; y_valid = 1'b0;
    check_eq("bp_pop_valid", 32'(rd_valid), 32'd1);
    check_eq("bp_pop_data", rd_data, 32'h100);
    check_eq("bp_fifo15", 32'(fifo_cnt), 32'd15);
    check_eq("bp_beat16", 32'(beat_cnt), 32'd16);
    for (int i = 1; i < 4; i++) pop_check("bp_rd", 32'h100 + 32'(i));
    for (int i = 0; i < 4; i++) send_beat(32'h110 + 32'(i), 4'hF);
    check_eq("bp_done", 32'(done), 32'd1);
    check_eq("bp_beat20", 32'(beat_cnt), 32'd20);
    check_eq("bp_fifo16", 32'(fifo_cnt), 32'd16);
    @(negedge clk);
    y_valid = 1'b1; #1;
    check_eq("bp_no_extra", 32'(y_ready), 32'd0);
    y_valid = 1'b0;
    for (int i = 0; i < 16; i++) pop_check("bp_drain", 32'h104 + 32'(i));

    // Strobe masking
    do_start(16'd1);
    send_beat(32'hAABB_CCDD, 4'b0101);
    check_eq("strb_done", 32'(done), 32'd1);
    check_eq("strb_sum", checksum, 32'h00BB_00DD);
    pop_check("strb_data", 32'h00BB_00DD);

    // Read on empty: no valid, data held
    rd_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rd_req = 1'b0;
    check_eq("empty_valid", 32'(rd_valid), 32'd0);
    check_eq("empty_hold", rd_data, 32'h00BB_00DD);
    check_eq("empty_fifo", 32'(fifo_cnt), 32'd0);

    // Zero length
    y_valid = 1'b1;
    do_start(16'd0);
    check_eq("zero_done", 32'(done), 32'd1);
    check_eq("zero_busy", 32'(busy), 32'd1);
    check_eq("zero_beat", 32'(beat_cnt), 32'd0);
    check_eq("zero_sum", checksum, 32'd0);
    #1;
    check_eq("zero_ready", 32'(y_ready), 32'd0);
    @(negedge clk);
    check_eq("zero_done_drop", 32'(done), 32'd0);
    check_eq("zero_busy_drop", 32'(busy), 32'd0);
    check_eq("zero_fifo", 32'(fifo_cnt), 32'd0);
    y_valid = 1'b0;

    // Clear mid-run
    do_start(16'd10);
    for (int i = 0; i < 5; i++) send_beat(32'h200 + 32'(i), 4'hF);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check_idle_empty("clr");
    check_eq("clr_rd_data", rd_data, 32'd0);

    // Reset mid-run, then a normal transfer
    @(negedge clk);
    do_start(16'd10);
    for (int i = 0; i < 5; i++) send_beat(32'h280 + 32'(i), 4'hF);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_idle_empty("rstrun");
    @(negedge clk);
    do_start(16'd3);
    for (int i = 0; i < 3; i++) send_beat(32'h300 + 32'(i), 4'hF);
    check_eq("rerun_done", 32'(done), 32'd1);
    check_eq("rerun_beat", 32'(beat_cnt), 32'd3);
    for (int i = 0; i < 3; i++) pop_check("rerun_rd", 32'h300 + 32'(i));

    // Random stalls, enable drops and reads over 512 beats
    do_start(16'd512);
    exp_sum = 32'h0;
    fork
      begin
        int sent, cyc;
        sent = 0; cyc = 0;
        while (sent < 512 && cyc < 20000) begin
          y_data  = golden(sent);
          y_strb  = 4'hF;
          y_valid = ($urandom_range(0, 9) != 0);
          enable  = ($urandom_range(0, 4) != 0);
          #1;
          if (y_valid && y_ready) begin
            exp_sum = rotl(exp_sum) ^ golden(sent);
            sent++;
          end
          @(negedge clk);
          cyc++;
        end
        y_valid = 1'b0;
        enable  = 1'b1;
        n_sent  = sent;
      end
      begin
        int rx, cyc;
        rx = 0; cyc = 0;
        while (rx < 512 && cyc < 25000) begin
          @(negedge clk);
          cyc++;
          if (rd_valid) begin
            check_eq("stall_data", rd_data, golden(rx));
            rx++;
          end
          rd_req = ($urandom_range(0, 9) < 6);
        end
        rd_req = 1'b0;
        n_rx = rx;
      end
    join
    check_eq("stall_sent", 32'(n_sent), 32'd512);
    check_eq("stall_rx", 32'(n_rx), 32'd512);
    check_eq("stall_beat", 32'(beat_cnt), 32'd512);
    check_eq("stall_sum", checksum, exp_sum);
    repeat (2) @(negedge clk);
    check_eq("stall_fifo", 32'(fifo_cnt), 32'd0);
    check_eq("stall_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fir_y_stream_sink.md
Name: fir_y_stream_sink

Overview:
- Synthesizable HWPE-Stream sink for the FIR output stream `y`; it is the consuming end of the stream that `fir_datapath` produces.
- Accepts a programmed number of beats and buffers them in a small FIFO, which a controller-side read port drains.
- Keeps a beat count and a rolling checksum so the surrounding accelerator can report completion and a result signature without a behavioural receiver.

Parameters:
- DATA_WIDTH, 32, width of y data; strobe width is DATA_WIDTH/8.
- DEPTH, 16, FIFO entries; power of two, at least 2.
- CNT_WIDTH, 16, width of the length and beat counters.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- clear_i  in  1  synchronous clear to post-reset state
- enable_i  in  1  local enable; 0 freezes acceptance
- start_i  in  1  one-cycle pulse; latches len_i
- len_i  in  CNT_WIDTH  number of beats to accept
- y  sink  hwpe_stream_intf_stream(DATA_WIDTH)  incoming FIR output stream (data, strb, valid, ready)
- rd_req_i  in  1  pop request for the read port
- rd_data_o  out  DATA_WIDTH  popped word, registered
- rd_valid_o  out  1  rd_data_o valid this cycle
- fifo_cnt_o  out  $clog2(DEPTH)+1  current FIFO occupancy
- beat_cnt_o  out  CNT_WIDTH  beats accepted since the last start
- checksum_o  out  DATA_WIDTH  rolling signature
- busy_o  out  1  FSM not in IDLE
- done_o  out  1  one-cycle completion pulse

Behaviour:
- Reset: rst_ni is asynchronous, active-low; clock is clk_i.
  - Outputs on reset: y.ready=0, rd_data_o=0, rd_valid_o=0, fifo_cnt_o=0, beat_cnt_o=0, checksum_o=0, busy_o=0, done_o=0.
  - Internal state on reset: FSM in IDLE, FIFO empty.
- clear_i: synchronous, highest priority. It produces the same state as reset on the next edge and discards the FIFO contents and any in-flight beat.
- FSM states: IDLE, RUN, DONE.
  - IDLE, start_i=1, len_i!=0: latch len_i; zero beat_cnt and checksum; go to RUN.
  - IDLE, start_i=1, len_i==0: zero beat_cnt and checksum; go to DONE.
  - RUN: when an accepted beat makes beat_cnt equal to len, go to DONE.
  - DONE: done_o=1 for exactly this cycle; go to IDLE.
  - start_i outside IDLE is ignored.
- Handshake:
  - y.ready = (state==RUN) & enable_i & ~fifo_full & ~(beat_cnt==len).
  - y.ready never depends on y.valid.
  - A beat is accepted on a rising edge where y.valid & y.ready.
  - FIFO full blocks acceptance even when the FIFO pops in the same cycle; there is no combinational full-to-ready pass-through.
- Strobe: bytes with strb=0 are written as 0x00. The masked word is what is stored and what enters the checksum.
- Checksum: on each accepted beat, checksum <= rotl(checksum,1) XOR masked_data. Update is visible the cycle after acceptance.
- beat_cnt increments by 1 per accepted beat. It is held in IDLE and DONE and is cleared only on the next start.
- FIFO:
  - DEPTH entries; pointers wrap modulo DEPTH.
  - Simultaneous push and pop: occupancy is unchanged and both operations take effect.
- Read port:
  - rd_req_i & ~empty pops the head.
  - rd_data_o and rd_valid_o=1 appear on the next cycle, so latency is 1.
  - rd_req_i on an empty FIFO is ignored: rd_valid_o=0 and rd_data_o holds its value.
  - The read port is active in every FSM state; the FIFO can be drained after done.
- enable_i=0 drops ready immediately in the same cycle. The FSM, counters and read port are unaffected.
- rst_ni asserted mid-RUN returns the block to IDLE with an empty FIFO; the upstream stream must be re-launched.

Test Plan:
- Basic: start with len=4, beats 0x11,0x22,0x33,0x44 with full strobe, no stalls.
  - Expect 4 handshakes, then done_o pulse one cycle after the 4th beat.
  - Expect beat_cnt_o=4, fifo_cnt_o=4; reads return 0x11..0x44 in order, each 1 cycle after rd_req_i.
  - Expect checksum 0x44 ^ rotl(0x33 ^ rotl(0x22 ^ rotl(0x11,1),1),1).
- Backpressure: start with len=20, DEPTH=16, no reads.
  - Expect ready=0 once fifo_cnt_o=16, holding 16 beats.
  - Assert rd_req_i and pop 4: expect exactly 4 further beats accepted, then done_o.
  - While full with a pop in progress, ready stays 0 in the pop cycle.
- Strobe and zero length:
  - Beat 0xAABBCCDD with strb=4'b0101 -> stored and checksummed as 0x00BB00DD.
  - start with len=0 -> done_o one cycle later, no handshakes, busy_o high for 1 cycle.
- Stalls: random y.valid with probability 0.9 and random enable_i; send 512 beats against a golden file.
  - Expect all 512 beats match in order, beat_cnt_o=512, no beat lost or duplicated across enable drops.
- Clear and reset mid-run: len=10, assert clear_i after 5 beats.
  - Next cycle: busy_o=0, fifo_cnt_o=0, beat_cnt_o=0, ready=0.
  - Repeat with rst_ni low for 2 cycles -> same result; a new start with len=3 then completes normally.
- Read on empty: rd_req_i with an empty FIFO -> rd_valid_o=0 and rd_data_o unchanged.
